output_deskew_buffer: RTL and testbench

OUTPUT_DESKEW_BUFFER -- requirements
Module: output_deskew_buffer

---
 rtl/output_deskew_buffer.sv | 99 +++++++++
 tb/tb_output_deskew_buffer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_deskew_buffer.sv
// Realigns a skewed systolic output stream into whole rows: lane i of beat k lands in row k-i,
// and a row becomes readable once its last lane (LANES-1) has been written.
module output_deskew_buffer #(
    parameter int unsigned LANES = 16,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic                  CLK,
    input  logic                  RETN,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_data,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic                  rd_req,
    output logic                  rd_valid,
    output logic [LANES*DW-1:0]   rd_data,
    output logic [AW:0]           count,
    output logic                  empty,
    output logic                  err_underflow
);

    localparam int unsigned KW = $clog2(LANES) + 1;

    // Pointers carry one extra wrap bit so occupancy is a plain subtraction.
    // wr_ptr tracks base + k; k_sat saturates at LANES-1 since only k >= i matters.
    logic [AW:0]          rd_ptr;
    logic [AW:0]          cm_ptr;
    logic [AW:0]          wr_ptr;
    logic [KW-1:0]        k_sat;
    logic [DW-1:0]        mem [LANES][DEPTH];

    logic                 accept;
    logic                 commit;
    logic                 pop;
    logic [AW:0]          eff_wr;
    logic [KW-1:0]        eff_k;
    logic [AW:0]          used;
    logic [LANES*DW-1:0]  rd_row;

    always_comb begin
        accept   = in_valid && in_ready;
        eff_wr   = in_first ? cm_ptr : wr_ptr;
        eff_k    = in_first ? '0 : k_sat;
        commit   = accept && (eff_k == KW'(LANES - 1));
        pop      = rd_req && (count != '0);
        used     = wr_ptr - rd_ptr;
        in_ready = !used[AW];
        empty    = (count == '0);
    end

    always_comb begin
        rd_row = '0;
        for (int i = 0; i < LANES; i++) begin
            rd_row[i*DW +: DW] = mem[i][rd_ptr[AW-1:0]];
        end
    end

    // Storage is deliberately not reset; rows only become readable through commit.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < LANES; i++) begin
            if (accept && (int'(eff_k) >= i)) begin
                mem[i][eff_wr[AW-1:0] - AW'(i)] <= in_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge CLK or negedge RETN) begin
        if (!RETN) begin
            rd_ptr        <= '0;
            cm_ptr        <= '0;
            wr_ptr        <= '0;
            k_sat         <= '0;
            count         <= '0;
            rd_valid      <= 1'b0;
            rd_data       <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (accept) begin
                if (in_last) begin
                    // Next frame starts right after the last committed row.
                    wr_ptr <= cm_ptr + {{AW{1'b0}}, commit};
                    k_sat  <= '0;
                end else begin
                    wr_ptr <= eff_wr + 1'b1;
                    k_sat  <= (eff_k == KW'(LANES - 1)) ? eff_k : eff_k + 1'b1;
                end
            end
            cm_ptr        <= cm_ptr + {{AW{1'b0}}, commit};
            rd_ptr        <= rd_ptr + {{AW{1'b0}}, pop};
            count         <= count + {{AW{1'b0}}, commit} - {{AW{1'b0}}, pop};
            rd_valid      <= pop;
            rd_data       <= pop ? rd_row : '0;
            err_underflow <= err_underflow || (rd_req && !pop);
        end
    end

endmodule

// File: tb/tb_output_deskew_buffer.sv
// Directed bench for output_deskew_buffer at 16 lanes x 8 bits x 32 rows.
module tb_output_deskew_buffer;

    localparam int LANES = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int LW    = LANES * DW;

    logic          CLK;
    logic          RETN;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] in_data;
    logic          in_first;
    logic          in_last;
    logic          rd_req;
    logic          rd_valid;
    logic [LW-1:0] rd_data;
    logic [AW:0]   count;
    logic          empty;
    logic          err_underflow;

    int n_cmp  = 0;
    int n_fail = 0;

    output_deskew_buffer #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .CLK           (CLK),
        .RETN          (RETN),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_first      (in_first),
        .in_last       (in_last),
        .rd_req        (rd_req),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .count         (count),
        .empty         (empty),
        .err_underflow (err_underflow)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit req;
        bit exp_valid;
        int exp_row;
        int exp_count;
        bit exp_empty;
        bit exp_err;
    } vec_t;

    function automatic logic [7:0] lane_val(int tag, int r, int i);
        return 8'(((tag + r) << 4) | i);
    endfunction

    function automatic logic [LW-1:0] row_val(int tag, int r);
        logic [LW-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = lane_val(tag, r, i);
        return v;
    endfunction

    function automatic logic [LW-1:0] beat_val(int tag, int k);
        logic [LW-1:0] v;
        v = '0;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = (k >= i) ? lane_val(tag, k - i, i) : 8'hEE;
        return v;
    endfunction

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one beat from a negedge; accepted on the next posedge, results visible at next negedge.
    task automatic drive_beat(input int tag, input int k, input bit first, input bit last,
                              input bit pop);
        int w;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge CLK);
            w++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_first = first;
        in_last  = last;
        in_data  = beat_val(tag, k);
        rd_req   = pop;
        @(negedge CLK);
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
        rd_req   = 1'b0;
    endtask

    task automatic send_frame(input int tag, input int nrows);
        for (int k = 0; k < nrows + LANES - 1; k++)
            drive_beat(tag, k, k == 0, k == nrows + LANES - 2, 1'b0);
    endtask

    task automatic pop_check(input string name, input int tag, input int r);
        rd_req = 1'b1;
        @(negedge CLK);
        rd_req = 1'b0;
        check({name, "_valid"}, LW'(rd_valid), 1);
        check({name, "_data"}, rd_data, row_val(tag, r));
    endtask

    vec_t vt[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  stall_f;
        int  stall_k;
        bit  stalled;

        vt[0] = '{req: 1, exp_valid: 1, exp_row: 0, exp_count: 3, exp_empty: 0, exp_err: 0};
        vt[1] = '{req: 1, exp_valid: 1, exp_row: 1, exp_count: 2, exp_empty: 0, exp_err: 0};
        vt[2] = '{req: 0, exp_valid: 0, exp_row: 0, exp_count: 2, exp_empty: 0, exp_err: 0};
        vt[3] = '{req: 1, exp_valid: 1, exp_row: 2, exp_count: 1, exp_empty: 0, exp_err: 0};
        vt[4] = '{req: 1, exp_valid: 1, exp_row: 3, exp_count: 0, exp_empty: 1, exp_err: 0};
        vt[5] = '{req: 1, exp_valid: 0, exp_row: 0, exp_count: 0, exp_empty: 1, exp_err: 1};

        RETN = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; rd_req = 1'b0;
        in_data = '0;
        #1;
        check("rst_count", LW'(count), 0);
        check("rst_empty", LW'(empty), 1);
        check("rst_in_ready", LW'(in_ready), 1);
        check("rst_rd_valid", LW'(rd_valid), 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_err", LW'(err_underflow), 0);
        repeat (2) @(negedge CLK);
        RETN = 1'b1;
        @(negedge CLK);

        // 4-row frame, then pops and an underflow from a table
        send_frame(0, 4);
        check("deskew_count", LW'(count), 4);
        for (int v = 0; v < 6; v++) begin
            rd_req = vt[v].req;
            @(negedge CLK);
            rd_req = 1'b0;
            check($sformatf("vec%0d_valid", v), LW'(rd_valid), LW'(vt[v].exp_valid));
            check($sformatf("vec%0d_data", v), rd_data,
                  vt[v].exp_valid ? row_val(0, vt[v].exp_row) : '0);
            check($sformatf("vec%0d_count", v), LW'(count), LW'(vt[v].exp_count));
            check($sformatf("vec%0d_empty", v), LW'(empty), LW'(vt[v].exp_empty));
            check($sformatf("vec%0d_err", v), LW'(err_underflow), LW'(vt[v].exp_err));
        end

        // Pop in the same cycle as the commit of row 3
        for (int k = 0; k < 20; k++) begin
            if (k == 18) check("sim_pre_count", LW'(count), 3);
            drive_beat(2, k, k == 0, k == 19, k == 18);
            if (k == 18) begin
                check("sim_count", LW'(count), 3);
                check("sim_valid", LW'(rd_valid), 1);
                check("sim_data", rd_data, row_val(2, 0));
            end
        end
        check("sim_post_count", LW'(count), 4);
        for (int r = 1; r < 5; r++) pop_check($sformatf("sim_pop%0d", r), 2, r);
        check("err_sticky", LW'(err_underflow), 1);

        // Abort a frame before any commit, then restart with in_first
        for (int k = 0; k < 10; k++) drive_beat(5, k, k == 0, 1'b0, 1'b0);
        check("abort_count", LW'(count), 0);
        send_frame(9, 3);
        check("restart_count", LW'(count), 3);
        for (int r = 0; r < 3; r++) pop_check($sformatf("restart_pop%0d", r), 9, r);
        check("restart_empty", LW'(empty), 1);

        // Three 8-row frames; the third crosses row 31 -> 0
        for (int f = 0; f < 3; f++) begin
            send_frame(f * 3 + 1, 8);
            check($sformatf("wrap%0d_count", f), LW'(count), 8);
            for (int r = 0; r < 8; r++) pop_check($sformatf("wrap%0d_pop%0d", f, r), f * 3 + 1, r);
        end

        // Backpressure: 2-row frames, no reads, until in_ready drops
        stalled = 1'b0; stall_f = -1; stall_k = -1;
        for (int f = 0; f < 9 && !stalled; f++) begin
            for (int k = 0; k < 17 && !stalled; k++) begin
                if (!in_ready) begin
                    stalled = 1'b1; stall_f = f; stall_k = k;
                end else begin
                    drive_beat(2 * f, k, k == 0, k == 16, 1'b0);
                end
            end
        end
        check("bp_stall_frame", LW'(stall_f), 8);
        check("bp_stall_beat", LW'(stall_k), 16);
        check("bp_count", LW'(count), 17);
        check("bp_ready_low", LW'(in_ready), 0);
        pop_check("bp_first_pop", 0, 0);
        check("bp_ready_high", LW'(in_ready), 1);
        drive_beat(16, 16, 1'b0, 1'b1, 1'b0);
        check("bp_final_count", LW'(count), 17);
        for (int f = 0; f < 9; f++)
            for (int r = 0; r < 2; r++)
                if (f != 0 || r != 0) pop_check($sformatf("bp_pop_f%0d_r%0d", f, r), 2 * f, r);
        check("bp_empty", LW'(empty), 1);

        // Reset with traffic and a pop landing in the same cycle
        send_frame(3, 2);
        rd_req = 1'b1; in_valid = 1'b1; in_first = 1'b1; in_data = beat_val(7, 0);
        @(posedge CLK);
        #1;
        check("prerst_valid", LW'(rd_valid), 1);
        RETN = 1'b0;
        #1;
        check("midrst_valid", LW'(rd_valid), 0);
        check("midrst_data", rd_data, 0);
        check("midrst_count", LW'(count), 0);
        check("midrst_empty", LW'(empty), 1);
        check("midrst_ready", LW'(in_ready), 1);
        check("midrst_err", LW'(err_underflow), 0);
        @(negedge CLK);
        rd_req = 1'b0; in_valid = 1'b0; in_first = 1'b0;
        RETN = 1'b1;
        @(negedge CLK);

        // First beat after reset is beat 0 even without in_first
        for (int k = 0; k < 16; k++) drive_beat(11, k, 1'b0, k == 15, 1'b0);
        check("postrst_count", LW'(count), 1);
        pop_check("postrst_pop", 11, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
